// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use stall, branch flush and EX operand
// forwarding control for the 5-stage RV32I core.
module id_ex_hazard_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        rs1_d,
  input  logic [4:0]        rs2_d,
  input  logic [4:0]        rd_d,
  input  logic [XLEN-1:0]   rd1_d,
  input  logic [XLEN-1:0]   rd2_d,
  input  logic [XLEN-1:0]   imm_d,
  input  logic [XLEN-1:0]   pc_d,
  input  logic [XLEN-1:0]   pcplus4_d,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic              pcsrc_e,
  input  logic [4:0]        rd_m,
  input  logic              regwrite_m,
  input  logic [4:0]        rd_w,
  input  logic              regwrite_w,
  output logic [4:0]        rs1_e,
  output logic [4:0]        rs2_e,
  output logic [4:0]        rd_e,
  output logic [XLEN-1:0]   rd1_e,
  output logic [XLEN-1:0]   rd2_e,
  output logic [XLEN-1:0]   imm_e,
  output logic [XLEN-1:0]   pc_e,
  output logic [XLEN-1:0]   pcplus4_e,
  output logic [CTRL_W-1:0] ctrl_e,
  output logic [1:0]        forward_a_e,
  output logic [1:0]        forward_b_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic [31:0]       stall_count
);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // MEM result is newer than WB, so it wins; x0 is hard-wired zero and never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] rdm, input logic wem,
                                         input logic [4:0] rdw, input logic wew);
    if (wem && (rdm != 5'd0) && (rdm == rs))      return FWD_MEM;
    else if (wew && (rdw != 5'd0) && (rdw == rs)) return FWD_WB;
    else                                          return FWD_RF;
  endfunction

  logic [4:0]        rs1_p1, rs2_p1, rd_p1;
  logic [XLEN-1:0]   rd1_p1, rd2_p1, imm_p1, pc_p1, pcplus4_p1;
  logic [CTRL_W-1:0] ctrl_p1;
  logic [31:0]       stall_cnt_p1;
  logic              lwstall;
  logic              flush_e;

  // Hazard detection: a load in E whose destination is read by the D instruction.
  always_comb begin
    lwstall = (ctrl_p1[2:1] == 2'b01) && (rd_p1 != 5'd0) &&
              ((rd_p1 == rs1_d) || (rd_p1 == rs2_d));
    flush_e = lwstall || pcsrc_e;
    stall_f = lwstall && !pcsrc_e;
    stall_d = lwstall && !pcsrc_e;
    flush_d = pcsrc_e;
  end

  // ---- stage D -> E boundary ----
  // E is never held: it either takes a zero bubble or the D instruction every cycle.
  always_ff @(posedge clk) begin
    if (reset || flush_e) begin
      rs1_p1     <= '0;
      rs2_p1     <= '0;
      rd_p1      <= '0;
      rd1_p1     <= '0;
      rd2_p1     <= '0;
      imm_p1     <= '0;
      pc_p1      <= '0;
      pcplus4_p1 <= '0;
      ctrl_p1    <= '0;
    end else begin
      rs1_p1     <= rs1_d;
      rs2_p1     <= rs2_d;
      rd_p1      <= rd_d;
      rd1_p1     <= rd1_d;
      rd2_p1     <= rd2_d;
      imm_p1     <= imm_d;
      pc_p1      <= pc_d;
      pcplus4_p1 <= pcplus4_d;
      ctrl_p1    <= ctrl_d;
    end
  end

  // Counts cycles in which fetch is actually held by a load-use hazard.
  always_ff @(posedge clk) begin
    if (reset)        stall_cnt_p1 <= '0;
    else if (stall_f) stall_cnt_p1 <= sat_inc(stall_cnt_p1);
  end

  // Forward selects come from registered E sources and the live M/W destinations.
  always_comb begin
    forward_a_e = fwd_sel(rs1_p1, rd_m, regwrite_m, rd_w, regwrite_w);
    forward_b_e = fwd_sel(rs2_p1, rd_m, regwrite_m, rd_w, regwrite_w);
  end

  assign rs1_e       = rs1_p1;
  assign rs2_e       = rs2_p1;
  assign rd_e        = rd_p1;
  assign rd1_e       = rd1_p1;
  assign rd2_e       = rd2_p1;
  assign imm_e       = imm_p1;
  assign pc_e        = pc_p1;
  assign pcplus4_e   = pcplus4_p1;
  assign ctrl_e      = ctrl_p1;
  assign stall_count = stall_cnt_p1;

endmodule
